dcache_store_buffer: RTL and testbench

Dcache-side responder for the store queue's retirement interface: accepts committed store packets from the store queue, returns same-cycle accept, and holds them in a small FIFO write buffer. It drains one word-masked write per transaction to the memory write port and mirrors each drained store into the cache data array. A load-side query port reports buffered bytes so loads never read memory that is older than a pending store.

---
 rtl/dcache_store_buffer.sv | 214 +++++++++++++++++++++
 tb/tb_dcache_store_buffer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_store_buffer.sv
// Store-queue retirement responder: FIFO write buffer draining to memory, mirrored into the
// cache data array, with load-side byte forwarding. Define WB_COALESCE_EN to merge same-word stores.
`ifndef NUM_SQ_DCACHE
`define NUM_SQ_DCACHE 2
`endif

package dcache_store_buffer_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  sign_size;
    logic [31:0] data;
  } SQ_DCACHE_PACKET;
endpackage

module dcache_store_buffer
  import dcache_store_buffer_pkg::*;
#(
  parameter int NUM_PORTS = `NUM_SQ_DCACHE,
  parameter int WB_DEPTH  = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  SQ_DCACHE_PACKET      sq_dcache_packet [NUM_PORTS],
  output logic [NUM_PORTS-1:0] dcache_accept,
  output logic                 mem_req_valid,
  output logic [31:0]          mem_req_addr,
  output logic [3:0]           mem_req_mask,
  output logic [31:0]          mem_req_data,
  input  logic                 mem_req_ready,
  output logic                 cache_wr_en,
  output logic [31:0]          cache_wr_addr,
  output logic [3:0]           cache_wr_mask,
  output logic [31:0]          cache_wr_data,
  input  logic [31:0]          ld_addr,
  output logic [3:0]           wb_fwd_mask,
  output logic [31:0]          wb_fwd_data,
  output logic                 wb_empty
);
  localparam int CW = $clog2(WB_DEPTH + 1);
  localparam int PW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;
  state_t state, state_next;

  logic [WB_DEPTH-1:0] wb_valid, valid_n;
  logic [29:0]         wb_waddr [WB_DEPTH];
  logic [29:0]         waddr_n  [WB_DEPTH];
  logic [3:0]          wb_mask  [WB_DEPTH];
  logic [3:0]          mask_n   [WB_DEPTH];
  logic [31:0]         wb_data  [WB_DEPTH];
  logic [31:0]         data_n   [WB_DEPTH];
  logic [PW-1:0]       head, tail, tail_n;
  logic [CW-1:0]       count, count_n, n_alloc;
  logic                pop;
  logic                unused_bits;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(WB_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return (p == '0) ? PW'(WB_DEPTH - 1) : p - PW'(1);
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [1:0] off,
                                            input logic [31:0] d);
    case (size)
      SZ_BYTE: return {24'd0, d[7:0]} << {off, 3'b000};
      SZ_HALF: return {16'd0, d[15:0]} << {off[1], 4'b0000};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] overlay(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  assign pop = (state == S_ISSUE) && mem_req_ready;

  // Accept/allocate: walk slots in order, stop at the first one that cannot be taken.
  always_comb begin
    logic        blocked;
    logic [3:0]  m;
    logic [31:0] d;
    logic [29:0] wa;
`ifdef WB_COALESCE_EN
    logic [PW-1:0] young;
    logic          young_ok;
    young    = ptr_dec(tail);
    young_ok = (count != '0) && !(state == S_ISSUE && young == head);
`endif
    valid_n       = wb_valid;
    waddr_n       = wb_waddr;
    mask_n        = wb_mask;
    data_n        = wb_data;
    dcache_accept = '0;
    tail_n        = tail;
    n_alloc       = '0;
    blocked       = reset;
    for (int i = 0; i < NUM_PORTS; i++) begin
      m  = lane_mask(sq_dcache_packet[i].sign_size[1:0], sq_dcache_packet[i].addr[1:0]);
      d  = lane_data(sq_dcache_packet[i].sign_size[1:0], sq_dcache_packet[i].addr[1:0],
                     sq_dcache_packet[i].data);
      wa = sq_dcache_packet[i].addr[31:2];
      if (blocked || !sq_dcache_packet[i].valid) begin
        blocked = 1'b1;
      end
`ifdef WB_COALESCE_EN
      else if (young_ok && waddr_n[young] == wa) begin
        dcache_accept[i] = 1'b1;
        mask_n[young]    = mask_n[young] | m;
        data_n[young]    = overlay(data_n[young], d, m);
      end
`endif
      else if ({1'b0, count} + {1'b0, n_alloc} < (CW+1)'(WB_DEPTH)) begin
        dcache_accept[i] = 1'b1;
        valid_n[tail_n]  = 1'b1;
        waddr_n[tail_n]  = wa;
        mask_n[tail_n]   = m;
        data_n[tail_n]   = d;
`ifdef WB_COALESCE_EN
        young    = tail_n;
        young_ok = 1'b1;
`endif
        tail_n  = ptr_inc(tail_n);
        n_alloc = n_alloc + CW'(1);
      end else begin
        blocked = 1'b1;
      end
    end
    if (pop) valid_n[head] = 1'b0;
  end

  assign count_n = count + n_alloc - CW'(pop);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (count_n != '0) state_next = S_ISSUE;
      S_ISSUE: if (count_n == '0) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      wb_valid <= '0;
    end else begin
      state    <= state_next;
      if (pop) head <= ptr_inc(head);
      tail     <= tail_n;
      count    <= count_n;
      wb_valid <= valid_n;
    end
  end

  // Entry payload carries no reset; validity alone qualifies it.
  always_ff @(posedge clock) begin
    wb_waddr <= waddr_n;
    wb_mask  <= mask_n;
    wb_data  <= data_n;
  end

  assign mem_req_valid = (state == S_ISSUE);
  assign mem_req_addr  = {wb_waddr[head], 2'b00};
  assign mem_req_mask  = wb_mask[head];
  assign mem_req_data  = wb_data[head];
  assign cache_wr_en   = pop;
  assign cache_wr_addr = mem_req_addr;
  assign cache_wr_mask = mem_req_mask;
  assign cache_wr_data = mem_req_data;
  assign wb_empty      = (count == '0);

  // Oldest to youngest, so later stores overwrite earlier bytes.
  always_comb begin
    logic [PW-1:0] idx;
    wb_fwd_mask = '0;
    wb_fwd_data = '0;
    idx         = head;
    for (int k = 0; k < WB_DEPTH; k++) begin
      if (wb_valid[idx] && wb_waddr[idx] == ld_addr[31:2]) begin
        wb_fwd_mask = wb_fwd_mask | wb_mask[idx];
        wb_fwd_data = overlay(wb_fwd_data, wb_data[idx], wb_mask[idx]);
      end
      idx = ptr_inc(idx);
    end
  end

  always_comb begin
    unused_bits = ^ld_addr[1:0];
    for (int i = 0; i < NUM_PORTS; i++)
      unused_bits = unused_bits ^ sq_dcache_packet[i].sign_size[2];
  end
endmodule

// File: tb/tb_dcache_store_buffer.sv
// Directed self-checking bench for dcache_store_buffer (2 ports, 4 entries).
module tb_dcache_store_buffer;
  import dcache_store_buffer_pkg::*;

  localparam logic [2:0] BYTE = 3'b000;
  localparam logic [2:0] HALF = 3'b001;
  localparam logic [2:0] WORD = 3'b010;

  logic            clock;
  logic            reset;
  SQ_DCACHE_PACKET pkt [2];
  logic [1:0]      dcache_accept;
  logic            mem_req_valid;
  logic [31:0]     mem_req_addr;
  logic [3:0]      mem_req_mask;
  logic [31:0]     mem_req_data;
  logic            mem_req_ready;
  logic            cache_wr_en;
  logic [31:0]     cache_wr_addr;
  logic [3:0]      cache_wr_mask;
  logic [31:0]     cache_wr_data;
  logic [31:0]     ld_addr;
  logic [3:0]      wb_fwd_mask;
  logic [31:0]     wb_fwd_data;
  logic            wb_empty;

  int checks = 0;
  int errors = 0;

  dcache_store_buffer #(.NUM_PORTS(2), .WB_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .sq_dcache_packet(pkt), .dcache_accept(dcache_accept),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_mask(mem_req_mask),
    .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready), .cache_wr_en(cache_wr_en),
    .cache_wr_addr(cache_wr_addr), .cache_wr_mask(cache_wr_mask), .cache_wr_data(cache_wr_data),
    .ld_addr(ld_addr), .wb_fwd_mask(wb_fwd_mask), .wb_fwd_data(wb_fwd_data), .wb_empty(wb_empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [31:0] a, input logic [2:0] sz,
                          input logic [31:0] d);
    pkt[i] = '{valid: 1'b1, addr: a, sign_size: sz, data: d};
  endtask

  task automatic clear_slots();
    pkt[0] = '0;
    pkt[1] = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    mem_req_ready = 1'b0;
    clear_slots();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_req_ready = 1'b0;
    ld_addr = 32'h80;
    set_slot(0, 32'h80, WORD, 32'h1);
    set_slot(1, 32'h84, WORD, 32'h2);
    #1;
    checks++; if (dcache_accept !== 2'b00) begin errors++;
      $display("FAIL reset_accept: got %b expected 00", dcache_accept); end
    tick();
    tick();
    reset = 1'b0;
    clear_slots();
    #1;
    checks++; if (mem_req_valid !== 1'b0) begin errors++;
      $display("FAIL reset_mem_valid: got %b expected 0", mem_req_valid); end
    checks++; if (cache_wr_en !== 1'b0) begin errors++;
      $display("FAIL reset_cache_wr: got %b expected 0", cache_wr_en); end
    checks++; if (wb_fwd_mask !== 4'h0) begin errors++;
      $display("FAIL reset_fwd_mask: got %h expected 0", wb_fwd_mask); end
    checks++; if (wb_empty !== 1'b1) begin errors++;
      $display("FAIL reset_empty: got %b expected 1", wb_empty); end
  endtask

  task automatic test_single_word();
    apply_reset();
    set_slot(0, 32'h100, WORD, 32'hDEADBEEF);
    mem_req_ready = 1'b1;
    #1;
    checks++; if (dcache_accept !== 2'b01) begin errors++;
      $display("FAIL single_accept: got %b expected 01", dcache_accept); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++;
      $display("FAIL single_no_comb_issue: got %b expected 0", mem_req_valid); end
    tick();
    clear_slots();
    checks++; if ({mem_req_valid, mem_req_addr, mem_req_mask, mem_req_data} !==
                  {1'b1, 32'h100, 4'hF, 32'hDEADBEEF}) begin errors++;
      $display("FAIL single_mem_req: got v=%b a=%h m=%h d=%h expected v=1 a=00000100 m=f d=deadbeef",
               mem_req_valid, mem_req_addr, mem_req_mask, mem_req_data); end
    checks++; if ({cache_wr_en, cache_wr_addr, cache_wr_mask, cache_wr_data} !==
                  {1'b1, 32'h100, 4'hF, 32'hDEADBEEF}) begin errors++;
      $display("FAIL single_cache_wr: got en=%b a=%h m=%h d=%h expected en=1 a=00000100 m=f d=deadbeef",
               cache_wr_en, cache_wr_addr, cache_wr_mask, cache_wr_data); end
    tick();
    checks++; if ({wb_empty, mem_req_valid, cache_wr_en} !== 3'b100) begin errors++;
      $display("FAIL single_drained: got empty/valid/wr=%b expected 100",
               {wb_empty, mem_req_valid, cache_wr_en}); end
    mem_req_ready = 1'b0;
  endtask

  task automatic test_align();
    apply_reset();
    set_slot(0, 32'h203, 3'b100, 32'hFFFF_FFAB);
    #1;
    checks++; if (dcache_accept !== 2'b01) begin errors++;
      $display("FAIL align_byte_accept: got %b expected 01", dcache_accept); end
    tick();
    clear_slots();
    checks++; if ({mem_req_addr, mem_req_mask, mem_req_data} !== {32'h200, 4'h8, 32'hAB000000})
    begin errors++;
      $display("FAIL align_byte: got a=%h m=%h d=%h expected a=00000200 m=8 d=ab000000",
               mem_req_addr, mem_req_mask, mem_req_data); end
    set_slot(0, 32'h202, 3'b101, 32'hFFFF1234);
    mem_req_ready = 1'b1;
    #1;
    checks++; if ({dcache_accept, cache_wr_en, cache_wr_mask} !== {2'b01, 1'b1, 4'h8}) begin
      errors++;
      $display("FAIL align_half_accept: got acc=%b wr=%b m=%h expected acc=01 wr=1 m=8",
               dcache_accept, cache_wr_en, cache_wr_mask); end
    tick();
    clear_slots();
    checks++; if ({mem_req_valid, mem_req_addr, mem_req_mask, mem_req_data} !==
                  {1'b1, 32'h200, 4'hC, 32'h12340000}) begin errors++;
      $display("FAIL align_half: got v=%b a=%h m=%h d=%h expected v=1 a=00000200 m=c d=12340000",
               mem_req_valid, mem_req_addr, mem_req_mask, mem_req_data); end
    tick();
    checks++; if (wb_empty !== 1'b1) begin errors++;
      $display("FAIL align_drained: got %b expected 1", wb_empty); end
    mem_req_ready = 1'b0;
  endtask

  task automatic test_full_backpressure();
    logic [31:0] exp_addr [4];
    exp_addr[0] = 32'h500; exp_addr[1] = 32'h504; exp_addr[2] = 32'h508; exp_addr[3] = 32'h50C;
    apply_reset();
    set_slot(0, 32'h500, WORD, 32'd1);
    set_slot(1, 32'h504, WORD, 32'd2);
    #1;
    checks++; if (dcache_accept !== 2'b11) begin errors++;
      $display("FAIL full_acc_c1: got %b expected 11", dcache_accept); end
    tick();
    set_slot(0, 32'h508, WORD, 32'd3);
    set_slot(1, 32'h50C, WORD, 32'd4);
    #1;
    checks++; if (dcache_accept !== 2'b11) begin errors++;
      $display("FAIL full_acc_c2: got %b expected 11", dcache_accept); end
    tick();
    set_slot(0, 32'h510, WORD, 32'd5);
    set_slot(1, 32'h514, WORD, 32'd6);
    #1;
    checks++; if (dcache_accept !== 2'b00) begin errors++;
      $display("FAIL full_acc_c3: got %b expected 00", dcache_accept); end
    for (int c = 0; c < 2; c++) begin
      checks++; if ({mem_req_valid, mem_req_addr, mem_req_data, cache_wr_en} !==
                    {1'b1, 32'h500, 32'd1, 1'b0}) begin errors++;
        $display("FAIL full_stable_%0d: got v=%b a=%h d=%h wr=%b expected v=1 a=00000500 d=1 wr=0",
                 c, mem_req_valid, mem_req_addr, mem_req_data, cache_wr_en); end
      tick();
    end
    pkt[1] = '0;
    mem_req_ready = 1'b1;
    #1;
    checks++; if (dcache_accept !== 2'b00) begin errors++;
      $display("FAIL full_pop_no_room: got %b expected 00", dcache_accept); end
    for (int k = 0; k < 4; k++) begin
      checks++; if ({cache_wr_en, mem_req_addr, mem_req_data} !== {1'b1, exp_addr[k], 32'(k + 1)})
      begin errors++;
        $display("FAIL full_drain_%0d: got wr=%b a=%h d=%h expected wr=1 a=%h d=%h",
                 k, cache_wr_en, mem_req_addr, mem_req_data, exp_addr[k], 32'(k + 1)); end
      tick();
      clear_slots();
    end
    checks++; if (wb_empty !== 1'b1) begin errors++;
      $display("FAIL full_drained: got %b expected 1", wb_empty); end
    mem_req_ready = 1'b0;
  endtask

  task automatic test_forwarding();
    apply_reset();
    ld_addr = 32'h300;
    set_slot(0, 32'h300, WORD, 32'h11223344);
    set_slot(1, 32'h301, BYTE, 32'h000000FF);
    #1;
    checks++; if ({dcache_accept, wb_fwd_mask} !== {2'b11, 4'h0}) begin errors++;
      $display("FAIL fwd_same_cycle: got acc=%b m=%h expected acc=11 m=0",
               dcache_accept, wb_fwd_mask); end
    tick();
    clear_slots();
    checks++; if ({wb_fwd_mask, wb_fwd_data} !== {4'hF, 32'h1122FF44}) begin errors++;
      $display("FAIL fwd_merge: got m=%h d=%h expected m=f d=1122ff44", wb_fwd_mask, wb_fwd_data); end
    ld_addr = 32'h304;
    #1;
    checks++; if (wb_fwd_mask !== 4'h0) begin errors++;
      $display("FAIL fwd_miss: got %h expected 0", wb_fwd_mask); end
  endtask

  task automatic test_coalesce();
    apply_reset();
    ld_addr = 32'h400;
    set_slot(0, 32'h400, BYTE, 32'h01);
    set_slot(1, 32'h401, BYTE, 32'h02);
    #1;
    checks++; if (dcache_accept !== 2'b11) begin errors++;
      $display("FAIL coal_accept: got %b expected 11", dcache_accept); end
    tick();
    clear_slots();
    checks++; if ({wb_fwd_mask, wb_fwd_data} !== {4'h3, 32'h00000201}) begin errors++;
      $display("FAIL coal_fwd: got m=%h d=%h expected m=3 d=00000201", wb_fwd_mask, wb_fwd_data); end
`ifdef WB_COALESCE_EN
    checks++; if ({mem_req_mask, mem_req_data} !== {4'h3, 32'h00000201}) begin errors++;
      $display("FAIL coal_head: got m=%h d=%h expected m=3 d=00000201", mem_req_mask, mem_req_data); end
    mem_req_ready = 1'b1;
    tick();
    checks++; if (wb_empty !== 1'b1) begin errors++;
      $display("FAIL coal_one_entry: got empty=%b expected 1", wb_empty); end
`else
    checks++; if ({mem_req_mask, mem_req_data} !== {4'h1, 32'h00000001}) begin errors++;
      $display("FAIL coal_head0: got m=%h d=%h expected m=1 d=00000001", mem_req_mask, mem_req_data); end
    mem_req_ready = 1'b1;
    tick();
    checks++; if ({wb_empty, mem_req_mask, mem_req_data} !== {1'b0, 4'h2, 32'h00000200}) begin
      errors++;
      $display("FAIL coal_head1: got e=%b m=%h d=%h expected e=0 m=2 d=00000200",
               wb_empty, mem_req_mask, mem_req_data); end
    tick();
    checks++; if (wb_empty !== 1'b1) begin errors++;
      $display("FAIL coal_two_entries: got empty=%b expected 1", wb_empty); end
`endif
    mem_req_ready = 1'b0;
  endtask

  task automatic test_reset_mid_issue();
    apply_reset();
    ld_addr = 32'h600;
    set_slot(0, 32'h600, WORD, 32'hA);
    set_slot(1, 32'h604, WORD, 32'hB);
    tick();
    pkt[1] = '0;
    set_slot(0, 32'h608, WORD, 32'hC);
    tick();
    checks++; if ({mem_req_valid, wb_empty, wb_fwd_mask} !== {1'b1, 1'b0, 4'hF}) begin errors++;
      $display("FAIL mid_pre: got v=%b e=%b m=%h expected v=1 e=0 m=f",
               mem_req_valid, wb_empty, wb_fwd_mask); end
    reset = 1'b1;
    set_slot(0, 32'h60C, WORD, 32'hD);
    #1;
    checks++; if (dcache_accept !== 2'b00) begin errors++;
      $display("FAIL mid_accept_in_reset: got %b expected 00", dcache_accept); end
    tick();
    reset = 1'b0;
    clear_slots();
    checks++; if ({mem_req_valid, wb_empty, wb_fwd_mask} !== {1'b0, 1'b1, 4'h0}) begin errors++;
      $display("FAIL mid_cleared: got v=%b e=%b m=%h expected v=0 e=1 m=0",
               mem_req_valid, wb_empty, wb_fwd_mask); end
    set_slot(0, 32'h700, WORD, 32'h77);
    #1;
    checks++; if (dcache_accept !== 2'b01) begin errors++;
      $display("FAIL mid_recover_accept: got %b expected 01", dcache_accept); end
    tick();
    clear_slots();
    checks++; if ({mem_req_valid, mem_req_addr, mem_req_data} !== {1'b1, 32'h700, 32'h77}) begin
      errors++;
      $display("FAIL mid_recover_issue: got v=%b a=%h d=%h expected v=1 a=00000700 d=77",
               mem_req_valid, mem_req_addr, mem_req_data); end
  endtask

  initial begin
    reset = 1'b1;
    mem_req_ready = 1'b0;
    ld_addr = '0;
    clear_slots();
    test_reset();
    test_single_word();
    test_align();
    test_full_backpressure();
    test_forwarding();
    test_coalesce();
    test_reset_mid_issue();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
